// File: rtl/fp_div_round_pack_if.sv
// Handshake and data bundle between the mantissa divider and the round/pack stage.
interface fp_div_round_pack_if #(
   parameter int EW = 8,
   parameter int MW = 23
);
   logic             start;
   logic             sign_a;
   logic             sign_b;
   logic [EW-1:0]    exp_a;
   logic [EW-1:0]    exp_b;
   logic [MW+2:0]    q;
   logic             sticky;
   logic             a_zero;
   logic             b_zero;
   logic             a_inf;
   logic             b_inf;
   logic             a_nan;
   logic             b_nan;
   logic [EW+MW:0]   result;
   logic             busy;
   logic             done;
   logic             flag_invalid;
   logic             flag_dz;
   logic             flag_overflow;
   logic             flag_underflow;
   logic             flag_inexact;

   modport master (
      output start, sign_a, sign_b, exp_a, exp_b, q, sticky,
             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan,
      input  result, busy, done, flag_invalid, flag_dz, flag_overflow,
             flag_underflow, flag_inexact
   );

   modport slave (
      input  start, sign_a, sign_b, exp_a, exp_b, q, sticky,
             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan,
      output result, busy, done, flag_invalid, flag_dz, flag_overflow,
             flag_underflow, flag_inexact
   );
endinterface

// File: rtl/fp_div_round_pack.sv
// Divider post-processing: normalizes the quotient, rounds to nearest-even,
// range-checks the exponent, resolves special operands and packs the result.
module fp_div_round_pack #(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input logic                clk,
   input logic                rst,
   fp_div_round_pack_if.slave bus
);
   localparam int XW = EW + 2;
   localparam logic signed [XW-1:0] BIAS    = XW'((32'sd2 ** (EW - 1)) - 32'sd1);
   localparam logic signed [XW-1:0] EXP_MAX = XW'((32'sd2 ** EW) - 32'sd1);
   localparam logic signed [XW-1:0] ONE     = XW'(32'sd1);
   localparam logic signed [XW-1:0] ZERO    = XW'(32'sd0);

   typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, PACK = 2'd3} state_t;

   state_t                 state_r, state_n;
   logic                   sign_r;
   logic [EW-1:0]          exp_a_r, exp_b_r;
   logic [MW+2:0]          q_r;
   logic                   sticky_r;
   logic                   a_zero_r, b_zero_r, a_inf_r, b_inf_r, a_nan_r, b_nan_r;
   logic [MW-1:0]          mant_r;
   logic                   guard_r, stk_r;
   logic signed [XW-1:0]   exp_r;
   logic [EW+MW:0]         result_r;
   logic                   busy_r, done_r;
   logic                   invalid_r, dz_r, overflow_r, underflow_r, inexact_r;

   logic [MW-1:0]          norm_mant_s;
   logic                   norm_guard_s, norm_stk_s;
   logic signed [XW-1:0]   exp_diff_s, norm_exp_s;
   logic                   rnd_up_s;
   logic [MW:0]            rnd_sum_s;
   logic signed [XW-1:0]   rnd_exp_s;
   logic [EW+MW:0]         pk_result_s;
   logic                   pk_invalid_s, pk_dz_s, pk_overflow_s, pk_underflow_s, pk_inexact_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic: start is only honoured in IDLE
   always_comb begin
      state_n = IDLE;
      case (state_r)
         IDLE:    if (bus.start) state_n = NORM; else state_n = IDLE;
         NORM:    state_n = ROUND;
         ROUND:   state_n = PACK;
         PACK:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Normalization; the divider supplies two extra fraction bits for guard/sticky
   always_comb begin
      exp_diff_s = $signed({2'b00, exp_a_r}) - $signed({2'b00, exp_b_r}) + BIAS;
      if (q_r[MW+2]) begin
         norm_mant_s  = q_r[MW+1:2];
         norm_guard_s = q_r[1];
         norm_stk_s   = q_r[0] | sticky_r;
         norm_exp_s   = exp_diff_s;
      end else begin
         norm_mant_s  = q_r[MW:1];
         norm_guard_s = q_r[0];
         norm_stk_s   = sticky_r;
         norm_exp_s   = exp_diff_s - ONE;
      end
   end

   // Round to nearest-even; a mantissa carry-out bumps the exponent
   always_comb begin
      rnd_up_s  = guard_r & (stk_r | mant_r[0]);
      rnd_sum_s = {1'b0, mant_r} + {{MW{1'b0}}, rnd_up_s};
      if (rnd_sum_s[MW]) begin
         rnd_exp_s = exp_r + ONE;
      end else begin
         rnd_exp_s = exp_r;
      end
   end

   // Special-case resolution and exponent range check
   always_comb begin
      pk_result_s    = '0;
      pk_invalid_s   = 1'b0;
      pk_dz_s        = 1'b0;
      pk_overflow_s  = 1'b0;
      pk_underflow_s = 1'b0;
      pk_inexact_s   = 1'b0;
      if (a_nan_r | b_nan_r | (a_zero_r & b_zero_r) | (a_inf_r & b_inf_r)) begin
         pk_result_s  = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
         pk_invalid_s = 1'b1;
      end else if (b_zero_r) begin
         pk_result_s = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
         pk_dz_s     = 1'b1;
      end else if (a_inf_r) begin
         pk_result_s = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
      end else if (a_zero_r | b_inf_r) begin
         pk_result_s = {sign_r, {(EW+MW){1'b0}}};
      end else if (exp_r >= EXP_MAX) begin
         pk_result_s   = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
         pk_overflow_s = 1'b1;
         pk_inexact_s  = 1'b1;
      end else if (exp_r <= ZERO) begin
         pk_result_s    = {sign_r, {(EW+MW){1'b0}}};
         pk_underflow_s = 1'b1;
         pk_inexact_s   = 1'b1;
      end else begin
         pk_result_s  = {sign_r, exp_r[EW-1:0], mant_r};
         pk_inexact_s = guard_r | stk_r;
      end
   end

   // Operand capture and per-stage datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_r   <= 1'b0;
         exp_a_r  <= '0;
         exp_b_r  <= '0;
         q_r      <= '0;
         sticky_r <= 1'b0;
         {a_zero_r, b_zero_r, a_inf_r, b_inf_r, a_nan_r, b_nan_r} <= 6'b000000;
         mant_r   <= '0;
         guard_r  <= 1'b0;
         stk_r    <= 1'b0;
         exp_r    <= ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  sign_r   <= bus.sign_a ^ bus.sign_b;
                  exp_a_r  <= bus.exp_a;
                  exp_b_r  <= bus.exp_b;
                  q_r      <= bus.q;
                  sticky_r <= bus.sticky;
                  {a_zero_r, b_zero_r, a_inf_r, b_inf_r, a_nan_r, b_nan_r} <=
                     {bus.a_zero, bus.b_zero, bus.a_inf, bus.b_inf, bus.a_nan, bus.b_nan};
               end
            end
            NORM: begin
               mant_r  <= norm_mant_s;
               guard_r <= norm_guard_s;
               stk_r   <= norm_stk_s;
               exp_r   <= norm_exp_s;
            end
            ROUND: begin
               mant_r <= rnd_sum_s[MW-1:0];
               exp_r  <= rnd_exp_s;
            end
            default: begin
               exp_r <= exp_r;
            end
         endcase
      end
   end

   // Output registers: result and flags change only on the PACK->IDLE edge
   always_ff @(posedge clk) begin
      if (rst) begin
         result_r    <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         invalid_r   <= 1'b0;
         dz_r        <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         inexact_r   <= 1'b0;
      end else begin
         busy_r <= (state_n != IDLE);
         done_r <= (state_r == PACK);
         if (state_r == PACK) begin
            result_r    <= pk_result_s;
            invalid_r   <= pk_invalid_s;
            dz_r        <= pk_dz_s;
            overflow_r  <= pk_overflow_s;
            underflow_r <= pk_underflow_s;
            inexact_r   <= pk_inexact_s;
         end
      end
   end

   assign bus.result         = result_r;
   assign bus.busy           = busy_r;
   assign bus.done           = done_r;
   assign bus.flag_invalid   = invalid_r;
   assign bus.flag_dz        = dz_r;
   assign bus.flag_overflow  = overflow_r;
   assign bus.flag_underflow = underflow_r;
   assign bus.flag_inexact   = inexact_r;
endmodule
